// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Bit counter must be able to hold the value WIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial shift datapath: synchronous clear, then shift in one bit per enable.
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (shift_en) begin
            if (MSB_FIRST != 0)
                r_q <= {r_q[WIDTH-2:0], s_in};
            else
                r_q <= {s_in, r_q[WIDTH-1:1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial word receiver: FSM, bit counter, parity accumulator and
// registered valid/ready output stage around sipo_shift_reg.
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_in,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_perr;
    logic             r_busy;
    logic             r_ovr;

    logic             w_clr;
    logic             w_shift;
    logic             w_ovr;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift),
        .s_in     (s_in),
        .q        (w_q)
    );

    // Word as it will look after this edge's shift; lets data_out load
    // on the same edge that samples the last data bit.
    assign w_q_next = (MSB_FIRST != 0) ? {w_q[WIDTH-2:0], s_in}
                                       : {s_in, w_q[WIDTH-1:1]};

    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_shift = 1'b0;
        w_ovr   = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next = S_SHIFT;
                        w_clr  = 1'b1;
                    end
                end
                S_SHIFT: begin
                    w_shift = 1'b1;
                    w_ovr   = start;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        if (PARITY_EN != 0)
                            w_next = S_PARITY;
                        else
                            w_next = S_HOLD;
                    end
                end
                S_PARITY: begin
                    w_ovr  = start;
                    w_next = S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (start) begin
                            w_next = S_SHIFT;
                            w_clr  = 1'b1;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else begin
                        w_ovr = start;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_HOLD);
            r_busy  <= (w_next == S_SHIFT) || (w_next == S_PARITY);
            r_ovr   <= w_ovr;
            if (abort || w_clr)
                r_cnt <= '0;
            else if (w_shift)
                r_cnt <= r_cnt + CW'(1);
            if (w_clr)
                r_par <= 1'b0;
            else if (w_shift)
                r_par <= r_par ^ s_in;
            if (r_state == S_SHIFT && w_next == S_HOLD) begin
                r_data <= w_q_next;
                r_perr <= 1'b0;
            end else if (r_state == S_PARITY && w_next == S_HOLD) begin
                r_data <= w_q;
                r_perr <= (PARITY_EN != 0) && (r_par ^ s_in);
            end
        end
    end

    assign data_out   = r_data;
    assign out_valid  = r_valid;
    assign parity_err = r_perr;
    assign busy       = r_busy;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl: three configurations share one stimulus.
module tb_sipo_rx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic s_in = 1'b0;
    logic abort = 1'b0;
    logic rdy = 1'b1;

    logic [7:0] m1_d, m0_d, p_d;
    logic m1_v, m1_pe, m1_b, m1_o;
    logic m0_v, m0_pe, m0_b, m0_o;
    logic p_v, p_pe, p_b, p_o;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    sipo_rx_ctrl #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_m1 (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in), .abort(abort),
        .data_out(m1_d), .out_valid(m1_v), .out_ready(rdy),
        .parity_err(m1_pe), .busy(m1_b), .overrun(m1_o)
    );

    sipo_rx_ctrl #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_m0 (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in), .abort(abort),
        .data_out(m0_d), .out_valid(m0_v), .out_ready(rdy),
        .parity_err(m0_pe), .busy(m0_b), .overrun(m0_o)
    );

    sipo_rx_ctrl #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_p (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in), .abort(abort),
        .data_out(p_d), .out_valid(p_v), .out_ready(rdy),
        .parity_err(p_pe), .busy(p_b), .overrun(p_o)
    );

    typedef struct {
        logic       st;
        logic       b;
        logic       ev;
        logic       eb;
        logic [7:0] ed;
        logic [7:0] e0d;
        logic       pv;
        logic       pb;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic st, input logic b, input logic ab);
        start = st;
        s_in  = b;
        abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic frame_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            cyc(1'b0, d[i], 1'b0);
    endtask

    initial begin
        // start, bit, m1 valid/busy/data, m0 data, par valid/busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hB3, 8'hCD, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hB3, 8'hCD, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hB3, 8'hCD, 1'b0, 1'b0};

        // reset state
        #2;
        chk("rst_m1_data", m1_d, 8'h00);
        chk("rst_m1_valid", m1_v, 1'b0);
        chk("rst_m1_busy", m1_b, 1'b0);
        chk("rst_m1_ovr", m1_o, 1'b0);
        chk("rst_p_perr", p_pe, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // frame B3: MSB-first, LSB-first and parity variants together
        rdy = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].st, tbl[i].b, 1'b0);
            chk($sformatf("t1_m1_valid[%0d]", i), m1_v, tbl[i].ev);
            chk($sformatf("t1_m1_busy[%0d]", i), m1_b, tbl[i].eb);
            chk($sformatf("t1_m1_data[%0d]", i), m1_d, tbl[i].ed);
            chk($sformatf("t1_m0_data[%0d]", i), m0_d, tbl[i].e0d);
            chk($sformatf("t1_m0_valid[%0d]", i), m0_v, tbl[i].ev);
            chk($sformatf("t1_p_valid[%0d]", i), p_v, tbl[i].pv);
            chk($sformatf("t1_p_busy[%0d]", i), p_b, tbl[i].pb);
            chk($sformatf("t1_m1_ovr[%0d]", i), m1_o, 1'b0);
            chk($sformatf("t1_p_perr[%0d]", i), p_pe, 1'b0);
        end

        // wrong parity bit
        cyc(1'b1, 1'b0, 1'b0);
        frame_bits(8'hB3);
        chk("t3_p_early", p_v, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_p_valid", p_v, 1'b1);
        chk("t3_p_perr", p_pe, 1'b1);
        chk("t3_p_data", p_d, 8'hB3);
        cyc(1'b0, 1'b0, 1'b0);

        // backpressure with dropped starts
        rdy = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        frame_bits(8'hB3);
        chk("t4_valid", m1_v, 1'b1);
        chk("t4_data", m1_d, 8'hB3);
        for (int i = 0; i < 6; i++) begin
            logic st;
            st = (i == 1) || (i == 3);
            cyc(st, 1'b1, 1'b0);
            chk($sformatf("t4_hold_valid[%0d]", i), m1_v, 1'b1);
            chk($sformatf("t4_hold_data[%0d]", i), m1_d, 8'hB3);
            chk($sformatf("t4_ovr[%0d]", i), m1_o, st);
        end
        rdy = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("t4_b2b_valid", m1_v, 1'b0);
        chk("t4_b2b_busy", m1_b, 1'b1);
        chk("t4_b2b_ovr", m1_o, 1'b0);
        frame_bits(8'h5A);
        chk("t4_5a_valid", m1_v, 1'b1);
        chk("t4_5a_data", m1_d, 8'h5A);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_drain", m1_v, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // abort mid-frame, then clean frame
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_abort_busy", m1_b, 1'b0);
        chk("t5_abort_valid", m1_v, 1'b0);
        chk("t5_abort_data", m1_d, 8'h5A);
        cyc(1'b1, 1'b0, 1'b0);
        frame_bits(8'h0F);
        chk("t5_0f_valid", m1_v, 1'b1);
        chk("t5_0f_data", m1_d, 8'h0F);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("t5_as_busy", m1_b, 1'b0);
        chk("t5_as_ovr", m1_o, 1'b0);
        chk("t5_as_valid", m1_v, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_idle_busy", m1_b, 1'b0);
        chk("t5_idle_ovr", m1_o, 1'b0);

        // async reset between edges
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t6_pre_busy", m1_b, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_data", m1_d, 8'h00);
        chk("t6_rst_busy", m1_b, 1'b0);
        chk("t6_rst_valid", m1_v, 1'b0);
        chk("t6_rst_ovr", m1_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        frame_bits(8'hFF);
        chk("t6_ff_valid", m1_v, 1'b1);
        chk("t6_ff_data", m1_d, 8'hFF);
        chk("t6_ff_m0", m0_d, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
Controller that sequences an internal serial-in/parallel-out shift register to capture fixed-width serial words, with an optional trailing even-parity bit. It takes a start strobe and a serial bit stream. It presents the assembled word on a valid/ready output handshake so a downstream consumer can apply backpressure. It sits between a serial line front-end and parallel consumers in the sequential-circuits library.

Parameters:
WIDTH, 8, number of data bits per word (2..32)
MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]
PARITY_EN, 0, 1: one even-parity bit follows the data bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin capture; sampled only in IDLE, or in HOLD together with a handshake
s_in  input  1  serial data bit, sampled on each rising edge in SHIFT/PARITY
abort  input  1  synchronous; returns to IDLE from any state, discards any partial or held word
data_out  output  WIDTH  captured word, stable while out_valid=1
out_valid  output  1  word available
out_ready  input  1  consumer accepts the word when out_valid & out_ready
parity_err  output  1  qualified by out_valid; 1 when the received parity does not make total ones even (always 0 if PARITY_EN=0)
busy  output  1  high in SHIFT or PARITY
overrun  output  1  one-cycle pulse when start is dropped because the block is not free

Behaviour:
- States: IDLE, SHIFT, PARITY (present only if PARITY_EN=1), HOLD.
- Reset (rst=0, asynchronous): state=IDLE. The shift register, bit counter, data_out, out_valid, parity_err, busy and overrun are all 0.
- IDLE:
  - start=1 -> SHIFT.
  - The shift register and bit counter clear on that edge.
  - s_in is ignored in that cycle.
- SHIFT:
  - Each edge shifts s_in into the register and increments the counter (width clog2(WIDTH+1)).
  - MSB_FIRST=1: shift left, with the new bit entering at bit 0. MSB_FIRST=0: shift right, with the new bit entering at bit WIDTH-1.
  - Timing: start sampled at edge k, data bits sampled at edges k+1 .. k+WIDTH.
  - On the edge that samples bit WIDTH:
    - PARITY_EN=0 -> HOLD. data_out loads the final word and out_valid=1 after edge k+WIDTH.
    - PARITY_EN=1 -> PARITY.
- PARITY:
  - Samples s_in at edge k+WIDTH+1 and goes to HOLD.
  - parity_err = XOR(data bits, parity bit).
  - out_valid=1 after edge k+WIDTH+1.
- HOLD:
  - out_valid=1, with data_out and parity_err frozen.
  - out_valid & out_ready at an edge completes the transfer. Next state is IDLE, or SHIFT if start=1 on the same edge (back-to-back frame with no idle cycle; counter and register clear). out_valid deasserts after that edge unless a new word completes.
- start in SHIFT, PARITY, or in HOLD without a handshake: ignored, and overrun=1 for the following cycle. The capture in progress is unaffected.
- abort=1 at an edge has highest priority over start and the handshake:
  - state->IDLE; out_valid, busy and the counter go to 0.
  - data_out keeps its value but is not valid.
  - abort and start together -> IDLE. No capture begins and no overrun pulse is raised.
- busy=1 exactly in SHIFT and PARITY.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-frame: immediate return to the reset state, and the partial word is lost.

Decomposition:
- Shared package sipo_pkg holds:
  - the state encoding enum (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, HOLD=2'd3);
  - constants for the default WIDTH and the counter-width function.
- One sub-module, sipo_shift_reg (clk, rst, clr, shift_en, s_in, q[WIDTH-1:0], parameters WIDTH and MSB_FIRST). It holds the parallel-load-free shift datapath.
- sipo_rx_ctrl keeps the FSM, the counter, the parity accumulator and the output register.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, PARITY_EN=0. Release rst; start pulse at edge 1; s_in=1,0,1,1,0,0,1,1 on edges 2..9; out_ready=1 -> out_valid high after edge 9, data_out=8'hB3, busy high for edges 2..9 only.
2. Same bits with MSB_FIRST=0 -> data_out=8'hCD.
3. PARITY_EN=1, bits for 8'hB3 (5 ones), parity bit 1 -> parity_err=0. Repeat with parity bit 0 -> parity_err=1. out_valid one cycle later than case 1.
4. Backpressure: out_ready=0 for 6 cycles after out_valid; pulse start during HOLD -> data_out stays 8'hB3, overrun pulses once per dropped start. Then out_ready=1 together with start -> the next frame begins immediately; a second word 8'h5A captures correctly.
5. Abort: abort at the 4th data bit, then start a fresh frame of 8'h0F -> data_out=8'h0F with no corruption from the aborted bits. abort+start in the same cycle -> stays IDLE, no overrun.
6. Async reset: assert rst=0 mid-SHIFT between clock edges -> all outputs 0 immediately. After release, the next frame of 8'hFF is captured correctly.
